bouncing_box: RTL



---
 rtl/bouncing_box_if.sv | 34 +++
 rtl/bouncing_box.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bouncing_box_if.sv
// bouncing_box_if: signal bundle between the video pipeline and bouncing_box.
//   master : sync generator / controller side (drives tick, controls, pixel coords)
//   slave  : bouncing_box side (drives position, direction, hit flags, bounce pulse)
// Parameter CW sets the coordinate width.
interface bouncing_box_if #(
  parameter int CW = 11
);
  logic          FRAME_TICK;
  logic          ENABLE;
  logic          MODE;
  logic          LOAD;
  logic [CW-1:0] X_LOAD;
  logic [CW-1:0] Y_LOAD;
  logic [CW-1:0] X_CONTROLLO;
  logic [CW-1:0] Y_CONTROLLO;
  logic [CW-1:0] X_POS;
  logic [CW-1:0] Y_POS;
  logic          DIR_X;
  logic          DIR_Y;
  logic          CONFERMA;
  logic          ESTERNO;
  logic          INTERNO;
  logic          BOUNCE;

  modport master (
    output FRAME_TICK, ENABLE, MODE, LOAD, X_LOAD, Y_LOAD, X_CONTROLLO, Y_CONTROLLO,
    input  X_POS, Y_POS, DIR_X, DIR_Y, CONFERMA, ESTERNO, INTERNO, BOUNCE
  );

  modport slave (
    input  FRAME_TICK, ENABLE, MODE, LOAD, X_LOAD, Y_LOAD, X_CONTROLLO, Y_CONTROLLO,
    output X_POS, Y_POS, DIR_X, DIR_Y, CONFERMA, ESTERNO, INTERNO, BOUNCE
  );
endinterface

// File: rtl/bouncing_box.sv
// bouncing_box: self-moving rectangle for the VGA pixel pipeline.
// Keeps a registered centre that advances STEP pixels per axis on each
// FRAME_TICK, reflects off the screen limits (optionally freezing for
// HOLD_FRAMES frames after a bounce), and answers registered per-pixel
// hit queries in filled (MODE=0) or frame-only (MODE=1) mode.
// Ports:
//   CLK     : pixel clock
//   RESET_N : asynchronous active-low reset
//   bus     : bouncing_box_if.slave (tick/controls/pixel in, position/hits out)
module bouncing_box #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int LARGHEZZA   = 100,
  parameter int ALTEZZA     = 100,
  parameter int SPESSORE    = 6,
  parameter int STEP        = 1,
  parameter int HOLD_FRAMES = 0,
  parameter int CW          = 11
) (
  input  logic          CLK,
  input  logic          RESET_N,
  bouncing_box_if.slave bus
);

  // One extra bit, signed, so centre minus half-size never wraps.
  typedef logic signed [CW:0] sc_t;

  localparam int CNTW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  typedef logic [CNTW-1:0] cnt_t;

  localparam sc_t XMIN   = sc_t'(LARGHEZZA / 2);
  localparam sc_t XMAX   = sc_t'(H_RES - 1 - LARGHEZZA / 2);
  localparam sc_t YMIN   = sc_t'(ALTEZZA / 2);
  localparam sc_t YMAX   = sc_t'(V_RES - 1 - ALTEZZA / 2);
  localparam sc_t HOX    = sc_t'(LARGHEZZA / 2);
  localparam sc_t HOY    = sc_t'(ALTEZZA / 2);
  localparam sc_t HIX    = sc_t'((LARGHEZZA - SPESSORE) / 2);
  localparam sc_t HIY    = sc_t'((ALTEZZA - SPESSORE) / 2);
  localparam sc_t STEP_S = sc_t'(STEP);
  localparam cnt_t HOLD_CNT = cnt_t'(HOLD_FRAMES);

  typedef enum logic {MOVE, HOLD} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  cnt_t          r_cnt;
  cnt_t          w_cnt_nxt;
  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic          r_dx;
  logic          r_dy;
  logic          r_conferma;
  logic          r_esterno;
  logic          r_interno;
  logic          r_bounce;

  sc_t  w_xs, w_ys, w_px, w_py, w_xl, w_yl;
  sc_t  w_x_inc, w_x_dec, w_y_inc, w_y_dec;
  sc_t  w_x_nxt, w_y_nxt;
  logic w_dx_nxt, w_dy_nxt;
  logic w_bx, w_by, w_bounce;
  logic w_out_hit, w_in_hit;

  assign w_xs = $signed({1'b0, r_x});
  assign w_ys = $signed({1'b0, r_y});
  assign w_px = $signed({1'b0, bus.X_CONTROLLO});
  assign w_py = $signed({1'b0, bus.Y_CONTROLLO});
  assign w_xl = $signed({1'b0, bus.X_LOAD});
  assign w_yl = $signed({1'b0, bus.Y_LOAD});

  assign w_x_inc = w_xs + STEP_S;
  assign w_x_dec = w_xs - STEP_S;
  assign w_y_inc = w_ys + STEP_S;
  assign w_y_dec = w_ys - STEP_S;

  // Strict inequalities on both sides: the edge pixel at exactly
  // centre +/- half-size is outside.
  assign w_out_hit = (w_px > w_xs - HOX) && (w_px < w_xs + HOX) &&
                     (w_py > w_ys - HOY) && (w_py < w_ys + HOY);
  assign w_in_hit  = (w_px > w_xs - HIX) && (w_px < w_xs + HIX) &&
                     (w_py > w_ys - HIY) && (w_py < w_ys + HIY);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_x_nxt     = w_xs;
    w_y_nxt     = w_ys;
    w_dx_nxt    = r_dx;
    w_dy_nxt    = r_dy;
    w_bx        = 1'b0;
    w_by        = 1'b0;
    w_bounce    = 1'b0;

    if (bus.LOAD) begin
      // LOAD overrides any tick in the same cycle and cancels a pending hold.
      if (w_xl < XMIN)      w_x_nxt = XMIN;
      else if (w_xl > XMAX) w_x_nxt = XMAX;
      else                  w_x_nxt = w_xl;
      if (w_yl < YMIN)      w_y_nxt = YMIN;
      else if (w_yl > YMAX) w_y_nxt = YMAX;
      else                  w_y_nxt = w_yl;
      w_state_nxt = MOVE;
      w_cnt_nxt   = '0;
    end else if (bus.FRAME_TICK) begin
      unique case (r_state)
        MOVE: begin
          if (bus.ENABLE) begin
            if (r_dx) begin
              if (w_x_inc > XMAX) begin
                w_x_nxt  = XMAX;
                w_dx_nxt = 1'b0;
                w_bx     = 1'b1;
              end else begin
                w_x_nxt = w_x_inc;
              end
            end else begin
              if (w_x_dec < XMIN) begin
                w_x_nxt  = XMIN;
                w_dx_nxt = 1'b1;
                w_bx     = 1'b1;
              end else begin
                w_x_nxt = w_x_dec;
              end
            end
            if (r_dy) begin
              if (w_y_inc > YMAX) begin
                w_y_nxt  = YMAX;
                w_dy_nxt = 1'b0;
                w_by     = 1'b1;
              end else begin
                w_y_nxt = w_y_inc;
              end
            end else begin
              if (w_y_dec < YMIN) begin
                w_y_nxt  = YMIN;
                w_dy_nxt = 1'b1;
                w_by     = 1'b1;
              end else begin
                w_y_nxt = w_y_dec;
              end
            end
            if (w_bx || w_by) begin
              w_bounce = 1'b1;
              if (HOLD_FRAMES > 0) begin
                w_state_nxt = HOLD;
                w_cnt_nxt   = HOLD_CNT;
              end
            end
          end
        end
        HOLD: begin
          // Counting ignores ENABLE; the tick that takes the counter to 0
          // already returns to MOVE, so motion resumes on the following tick.
          if (r_cnt <= cnt_t'(1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = MOVE;
          end else begin
            w_cnt_nxt = r_cnt - cnt_t'(1);
          end
        end
        default: w_state_nxt = MOVE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= MOVE;
      r_cnt      <= '0;
      r_x        <= CW'(H_RES / 2);
      r_y        <= CW'(V_RES / 2);
      r_dx       <= 1'b1;
      r_dy       <= 1'b1;
      r_conferma <= 1'b0;
      r_esterno  <= 1'b0;
      r_interno  <= 1'b0;
      r_bounce   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_x        <= w_x_nxt[CW-1:0];
      r_y        <= w_y_nxt[CW-1:0];
      r_dx       <= w_dx_nxt;
      r_dy       <= w_dy_nxt;
      r_esterno  <= w_out_hit;
      r_interno  <= w_in_hit;
      r_conferma <= bus.MODE ? (w_out_hit && !w_in_hit) : w_out_hit;
      r_bounce   <= w_bounce;
    end
  end

  assign bus.X_POS    = r_x;
  assign bus.Y_POS    = r_y;
  assign bus.DIR_X    = r_dx;
  assign bus.DIR_Y    = r_dy;
  assign bus.CONFERMA = r_conferma;
  assign bus.ESTERNO  = r_esterno;
  assign bus.INTERNO  = r_interno;
  assign bus.BOUNCE   = r_bounce;

endmodule
